// File: rtl/spi_burst_arbiter.sv
// Round-robin arbiter and burst sequencer for two requesters sharing one
// byte-level SPI master; owns chip select and the setup/hold/gap timing.
module spi_burst_arbiter #(
  parameter int DW       = 8,
  parameter int LEN_W    = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [2*LEN_W-1:0] len,
  input  logic [2*DW-1:0]    tx_data,
  output logic [1:0]         tx_pop,
  output logic [1:0]         gnt,
  output logic [DW-1:0]      rx_data,
  output logic [1:0]         rx_valid,
  output logic [1:0]         done,
  output logic [1:0]         err,
  output logic               cs_n,
  output logic [DW-1:0]      m_tx_data,
  output logic               m_req,
  input  logic               m_busy,
  input  logic [DW-1:0]      m_rx_data,
  input  logic               m_rx_valid
);

  typedef enum logic [2:0] {
    IDLE, GRANT, SETUP, ISSUE, WAIT, HOLD, GAP
  } state_t;

  state_t            state, state_d;
  logic              owner, owner_d;
  logic              last, last_d;
  logic              aborted, aborted_d;
  logic [LEN_W-1:0]  remaining, remaining_d;
  logic [15:0]       cnt, cnt_d;
  logic [15:0]       tcnt, tcnt_d;
  logic [1:0]        tx_pop_d, gnt_d;
  logic [1:0]        rx_valid_d, done_d, err_d;
  logic [DW-1:0]     rx_data_d, m_tx_data_d;
  logic              cs_n_d, m_req_d;

  logic [LEN_W-1:0]  len_sel;
  logic [DW-1:0]     tx_sel;

  assign len_sel = owner ? len[LEN_W +: LEN_W] : len[0 +: LEN_W];
  assign tx_sel  = owner ? tx_data[DW +: DW] : tx_data[0 +: DW];

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      aborted   <= 1'b0;
      remaining <= '0;
      cnt       <= '0;
      tcnt      <= '0;
      tx_pop    <= '0;
      gnt       <= '0;
      rx_data   <= '0;
      rx_valid  <= '0;
      done      <= '0;
      err       <= '0;
      cs_n      <= 1'b1;
      m_tx_data <= '0;
      m_req     <= 1'b0;
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      last      <= last_d;
      aborted   <= aborted_d;
      remaining <= remaining_d;
      cnt       <= cnt_d;
      tcnt      <= tcnt_d;
      tx_pop    <= tx_pop_d;
      gnt       <= gnt_d;
      rx_data   <= rx_data_d;
      rx_valid  <= rx_valid_d;
      done      <= done_d;
      err       <= err_d;
      cs_n      <= cs_n_d;
      m_tx_data <= m_tx_data_d;
      m_req     <= m_req_d;
    end
  end

  always_comb begin
    state_d     = state;
    owner_d     = owner;
    last_d      = last;
    aborted_d   = aborted;
    remaining_d = remaining;
    cnt_d       = cnt;
    tcnt_d      = tcnt;
    tx_pop_d    = '0;
    gnt_d       = gnt;
    rx_data_d   = rx_data;
    rx_valid_d  = '0;
    done_d      = '0;
    err_d       = '0;
    cs_n_d      = cs_n;
    m_tx_data_d = m_tx_data;
    m_req_d     = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          owner_d = (&req) ? ~last : req[1];
        end
      end
      GRANT: begin
        remaining_d = (len_sel == '0) ? LEN_W'(1) : len_sel;
        gnt_d       = owner ? 2'b10 : 2'b01;
        cs_n_d      = 1'b0;
        cnt_d       = '0;
        aborted_d   = 1'b0;
        state_d     = SETUP;
      end
      SETUP: begin
        if (cnt == 16'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = ISSUE;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      ISSUE: begin
        if (!m_busy) begin
          m_req_d         = 1'b1;
          m_tx_data_d     = tx_sel;
          tx_pop_d[owner] = 1'b1;
          tcnt_d          = '0;
          state_d         = WAIT;
        end
      end
      WAIT: begin
        if (m_rx_valid) begin
          rx_data_d         = m_rx_data;
          rx_valid_d[owner] = 1'b1;
          remaining_d       = remaining - LEN_W'(1);
          cnt_d             = '0;
          state_d = (remaining == LEN_W'(1)) ? HOLD : ISSUE;
        end else if (tcnt == 16'(TIMEOUT - 1)) begin
          // Abort: the slave never answered this byte.
          err_d[owner] = 1'b1;
          remaining_d  = '0;
          aborted_d    = 1'b1;
          cnt_d        = '0;
          state_d      = HOLD;
        end else if (tcnt < 16'(TIMEOUT)) begin
          tcnt_d = tcnt + 16'd1;
        end
      end
      HOLD: begin
        if (cnt == 16'(CS_HOLD - 1)) begin
          cs_n_d  = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
          if (!aborted) done_d[owner] = 1'b1;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      GAP: begin
        if (cnt == 16'(CS_GAP - 1)) begin
          gnt_d   = '0;
          last_d  = owner;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_burst_arbiter.sv
// Randomized scoreboard bench for spi_burst_arbiter with a behavioural
// SPI master that answers each byte with its bitwise complement.
module tb_spi_burst_arbiter;

  localparam int DW       = 8;
  localparam int LEN_W    = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_GAP   = 2;
  localparam int TIMEOUT  = 255;
  localparam int MLAT     = 80;

  localparam int K_MREQ = 0;
  localparam int K_RX   = 1;
  localparam int K_DONE = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int kind;
    int ch;
    int data;
  } ev_t;

  logic               sysclk = 1'b0;
  logic               rst;
  logic [1:0]         req;
  logic [2*LEN_W-1:0] len;
  logic [2*DW-1:0]    tx_data;
  logic [1:0]         tx_pop, gnt, rx_valid, done, err;
  logic [DW-1:0]      rx_data, m_tx_data, m_rx_data, mbyte;
  logic               cs_n, m_req, m_busy, m_rx_valid;

  ev_t  exp_q[$];
  int   cs_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   mcnt;
  int   mdelay;
  int   last_srv;
  int   txidx [2];
  logic [7:0] txbuf [2][16];
  bit   wd_hit = 1'b0;
  bit   fin = 1'b0;

  spi_burst_arbiter #(
    .DW(DW), .LEN_W(LEN_W), .CS_SETUP(CS_SETUP),
    .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .sysclk(sysclk), .rst(rst), .req(req), .len(len),
    .tx_data(tx_data), .tx_pop(tx_pop), .gnt(gnt),
    .rx_data(rx_data), .rx_valid(rx_valid), .done(done),
    .err(err), .cs_n(cs_n), .m_tx_data(m_tx_data),
    .m_req(m_req), .m_busy(m_busy), .m_rx_data(m_rx_data),
    .m_rx_valid(m_rx_valid)
  );

  always #5 sysclk = ~sysclk;

  // m_rx_valid arrives mdelay cycles after the m_req cycle
  always @(posedge sysclk) begin
    if (rst) begin
      m_busy     <= 1'b0;
      m_rx_valid <= 1'b0;
      m_rx_data  <= '0;
      mbyte      <= '0;
      mcnt       <= 0;
    end else begin
      m_rx_valid <= 1'b0;
      if (m_req) begin
        m_busy <= 1'b1;
        mcnt   <= mdelay - 1;
        mbyte  <= ~m_tx_data;
      end else if (mcnt > 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) begin
          m_busy     <= 1'b0;
          m_rx_valid <= 1'b1;
          m_rx_data  <= mbyte;
        end
      end
    end
  end

  function automatic int pick(input logic [1:0] r, input int lst);
    if (r == 2'b11) return 1 - lst;
    return r[1] ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, want);
    end
  endtask

  task automatic expect_ev(input string nm, input int k,
                           input int ch, input int d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected ch=%0d data=%0h", nm, ch, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.ch != ch || e.data != d) begin
        failures++;
        $display("FAIL %s got kind=%0d ch=%0d data=%0h want kind=%0d ch=%0d data=%0h",
                 nm, k, ch, d, e.kind, e.ch, e.data);
      end
    end
  endtask

  initial begin : monitor
    int   lowcnt, highcnt, last_mreq, want;
    bit   rst_q, had_burst;
    lowcnt = 0; highcnt = 0; last_mreq = 0;
    rst_q = 1'b0; had_burst = 1'b0;
    forever begin
      @(negedge sysclk);
      cyc++;
      if (rst) begin
        if (rst_q) begin
          chk("rst_cs_n", int'(cs_n), 1);
          chk("rst_gnt", int'(gnt), 0);
          chk("rst_m_req", int'(m_req), 0);
          chk("rst_done", int'(done), 0);
          chk("rst_pulses", int'({tx_pop, rx_valid, err}), 0);
          chk("rst_data", int'({rx_data, m_tx_data}), 0);
        end
        rst_q = 1'b1;
        lowcnt = 0; highcnt = 0; had_burst = 1'b0;
      end else begin
        rst_q = 1'b0;
        if (m_req) begin
          chk("mreq_cs_low", int'(cs_n), 0);
          chk("pop_is_owner", int'(tx_pop), int'(gnt));
          last_mreq = cyc;
          expect_ev("mreq", K_MREQ, int'(gnt[1]), int'(m_tx_data));
        end else if (tx_pop != 2'b00) begin
          chk("pop_stray", int'(tx_pop), 0);
        end
        if (rx_valid != 2'b00) begin
          chk("rxv_is_owner", int'(rx_valid), int'(gnt));
          expect_ev("rx", K_RX, int'(rx_valid[1]), int'(rx_data));
        end
        if (done != 2'b00) begin
          chk("done_is_owner", int'(done), int'(gnt));
          expect_ev("done", K_DONE, int'(done[1]), 0);
        end
        if (err != 2'b00) begin
          chk("err_is_owner", int'(err), int'(gnt));
          expect_ev("err", K_ERR, int'(err[1]), cyc - last_mreq);
        end
        if (!cs_n) begin
          if (highcnt > 0 && had_burst) begin
            checks++;
            if (highcnt < CS_GAP) begin
              failures++;
              $display("FAIL cs_gap got=%0d want>=%0d", highcnt, CS_GAP);
            end
          end
          highcnt = 0;
          lowcnt++;
        end else begin
          if (lowcnt > 0) begin
            want = (cs_q.size() > 0) ? cs_q.pop_front() : -1;
            chk("cs_low_len", lowcnt, want);
            had_burst = 1'b1;
          end
          lowcnt = 0;
          highcnt++;
        end
      end
      if (fin || cyc >= 90000) begin
        chk("finished_in_time", int'(fin), 1);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("cs_q_empty", cs_q.size(), 0);
        chk("watchdog", int'(wd_hit), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  task automatic drive_tx();
    for (int c = 0; c < 2; c++)
      tx_data[c*DW +: DW] = txbuf[c][txidx[c] & 15];
  endtask

  task automatic service();
    for (int c = 0; c < 2; c++) begin
      if (tx_pop[c]) txidx[c]++;
      if (done[c] | err[c]) req[c] = 1'b0;
    end
    drive_tx();
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge sysclk);
      #2;
      service();
    end
  endtask

  task automatic prep();
    for (int c = 0; c < 2; c++) begin
      txidx[c] = 0;
      for (int i = 0; i < 16; i++) txbuf[c][i] = 8'($urandom);
    end
  endtask

  task automatic push_burst(input int ch, input int l, input bit abort);
    int n;
    logic [7:0] b;
    n = (l == 0) ? 1 : l;
    if (abort) begin
      exp_q.push_back('{K_MREQ, ch, int'(txbuf[ch][0])});
      exp_q.push_back('{K_ERR, ch, TIMEOUT});
      cs_q.push_back(CS_SETUP + 1 + TIMEOUT + CS_HOLD);
    end else begin
      for (int i = 0; i < n; i++) begin
        b = ~txbuf[ch][i];
        exp_q.push_back('{K_MREQ, ch, int'(txbuf[ch][i])});
        exp_q.push_back('{K_RX, ch, int'(b)});
      end
      exp_q.push_back('{K_DONE, ch, 0});
      // setup, then per byte one issue cycle plus the master round trip
      cs_q.push_back(CS_SETUP + n * (MLAT + 2) + CS_HOLD);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(posedge sysclk);
      #2;
      service();
      if (req == 2'b00 && gnt == 2'b00) ok = 1'b1;
    end
    if (!ok) begin
      wd_hit = 1'b1;
      req = 2'b00;
    end
  endtask

  task automatic start(input logic [1:0] r, input int l0, input int l1,
                       input bit abort);
    int w;
    w = pick(r, last_srv);
    push_burst(w, w ? l1 : l0, abort);
    if (r == 2'b11) push_burst(1 - w, w ? l0 : l1, abort);
    last_srv = (r == 2'b11) ? 1 - w : w;
    len = {LEN_W'(l1), LEN_W'(l0)};
    drive_tx();
    req = r;
    wait_idle(8000);
    tick(3);
  endtask

  initial begin : stimulus
    logic [1:0] r;
    int l0, l1, k;
    rst = 1'b1;
    req = '0;
    len = '0;
    tx_data = '0;
    mdelay = MLAT;
    last_srv = 1;
    prep();
    repeat (3) @(posedge sysclk);
    #2;
    rst = 1'b0;
    tick(2);

    prep();
    start(2'b11, 3, 3, 1'b0);
    prep();
    start(2'b11, 2, 1, 1'b0);
    prep();
    txbuf[0][0] = 8'hA3;
    start(2'b01, 1, 0, 1'b0);
    prep();
    start(2'b11, 1, 2, 1'b0);
    prep();
    start(2'b01, 0, 0, 1'b0);
    prep();
    start(2'b10, 0, 2, 1'b0);

    mdelay = 300;
    prep();
    start(2'b01, 3, 0, 1'b1);
    tick(60);
    mdelay = MLAT;

    for (int t = 0; t < 8; t++) begin
      r  = 2'($urandom_range(1, 3));
      l0 = $urandom_range(0, 3);
      l1 = $urandom_range(0, 3);
      prep();
      start(r, l0, l1, 1'b0);
    end

    prep();
    push_burst(0, 4, 1'b0);
    len = {LEN_W'(0), LEN_W'(4)};
    drive_tx();
    req = 2'b01;
    k = 0;
    while (txidx[0] < 2 && k < 2000) begin
      tick(1);
      k++;
    end
    if (txidx[0] < 2) wd_hit = 1'b1;
    tick(10);
    rst = 1'b1;
    req = 2'b00;
    repeat (2) @(posedge sysclk);
    #2;
    exp_q.delete();
    cs_q.delete();
    rst = 1'b0;
    last_srv = 1;
    tick(2);

    prep();
    start(2'b01, 1, 0, 1'b0);
    prep();
    start(2'b11, 1, 1, 1'b0);
    tick(5);
    fin = 1'b1;
  end

endmodule
